// File: rtl/video_stream_source.sv
// Video stream source: frame/line timing plus a 2-entry prefetch buffer fed by a 1-cycle-latency
// frame-buffer read port. Define TEST_PATTERN_EN to enable the internal pattern selected by pattern_sel.
module video_stream_source #(
  parameter int H_ACTIVE  = 702,
  parameter int V_ACTIVE  = 288,
  parameter int LINE_GAP  = 16,
  parameter int FRAME_GAP = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        pattern_sel,
  output logic        mem_rd_en,
  output logic [19:0] mem_rd_addr,
  input  logic [7:0]  mem_rd_data,
  output logic        video_frame_valid,
  output logic        video_line_valid,
  output logic        video_data_valid,
  input  logic        video_data_ready,
  output logic [7:0]  video_data_out,
  output logic [19:0] video_address
);

  localparam int GAP_MAX = (FRAME_GAP > LINE_GAP) ? FRAME_GAP : LINE_GAP;
  localparam int GW      = $clog2(GAP_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FGAP = 3'd1,
    S_LGAP = 3'd2,
    S_LINE = 3'd3,
    S_TAIL = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [9:0]    rd_h_q, rd_h_d;
  logic [9:0]    out_h_q, out_h_d;
  logic [8:0]    v_q, v_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [7:0]    buf0_q, buf0_d;
  logic [7:0]    buf1_q, buf1_d;
  logic          pop_s;
  logic          issue_s;
  logic          last_s;
  logic          frame_start_s;
  logic [2:0]    occ_s;
  logic [7:0]    in_data_s;

  // Occupancy counts the slot freed by a pixel leaving this cycle, so a full-rate line never bubbles.
  assign pop_s   = (cnt_q != 2'd0) && video_data_ready;
  assign occ_s   = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop_s};
  assign issue_s = (state_q == S_LINE) && (rd_h_q < 10'(H_ACTIVE)) && (occ_s < 3'd2);
  assign last_s  = pop_s && (out_h_q == 10'(H_ACTIVE - 1));

`ifdef TEST_PATTERN_EN
  logic       pat_q, pat_d;
  logic [7:0] gen_q, gen_d;

  assign pat_d     = frame_start_s ? pattern_sel : pat_q;
  assign gen_d     = issue_s ? (((rd_h_q[5] ^ v_q[4]) == 1'b1) ? 8'd200 : 8'd20) : gen_q;
  assign in_data_s = pat_q ? gen_q : mem_rd_data;
  assign mem_rd_en = issue_s & ~pat_q;

  // Pattern select latch and generator pixel, timed like a memory read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q <= 1'b0;
      gen_q <= 8'd0;
    end else begin
      pat_q <= pat_d;
      gen_q <= gen_d;
    end
  end
`else
  logic [1:0] unused_s;

  assign unused_s  = {pattern_sel, frame_start_s};
  assign in_data_s = mem_rd_data;
  assign mem_rd_en = issue_s;
`endif

  assign mem_rd_addr       = {v_q, 1'b0, rd_h_q};
  assign video_frame_valid = (state_q == S_LGAP) || (state_q == S_LINE) || (state_q == S_TAIL);
  assign video_line_valid  = (state_q == S_LINE);
  assign video_data_valid  = (cnt_q != 2'd0);
  assign video_data_out    = buf0_q;
  assign video_address     = {v_q, 1'b0, out_h_q};

  // Next-state logic for the frame FSM, counters and prefetch buffer.
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    rd_h_d        = rd_h_q;
    out_h_d       = out_h_q;
    v_d           = v_q;
    cnt_d         = cnt_q;
    pend_d        = 1'b0;
    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    frame_start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d       = S_FGAP;
          gap_d         = GW'(1);  // the IDLE cycle is the first gap clock
          frame_start_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FGAP: begin
        if (gap_q == GW'(FRAME_GAP - 1)) begin
          state_d = S_LGAP;
          gap_d   = '0;
          v_d     = 9'd0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_LGAP: begin
        if (gap_q == GW'(LINE_GAP - 1)) begin
          state_d = S_LINE;
          gap_d   = '0;
          rd_h_d  = 10'd0;
          out_h_d = 10'd0;
          cnt_d   = 2'd0;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_LINE: begin
        pend_d = issue_s;
        if (issue_s) begin
          rd_h_d = rd_h_q + 10'd1;
        end else begin
          rd_h_d = rd_h_q;
        end
        // Head of the buffer is always entry 0; returning data lands behind what remains.
        case ({pend_q, pop_s})
          2'b10: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd0) begin
              buf0_d = in_data_s;
            end else begin
              buf1_d = in_data_s;
            end
          end
          2'b01: begin
            cnt_d  = cnt_q - 2'd1;
            buf0_d = buf1_q;
          end
          2'b11: begin
            if (cnt_q == 2'd1) begin
              buf0_d = in_data_s;
            end else begin
              buf0_d = buf1_q;
              buf1_d = in_data_s;
            end
          end
          default: cnt_d = cnt_q;
        endcase
        if (pop_s) begin
          out_h_d = out_h_q + 10'd1;
        end else begin
          out_h_d = out_h_q;
        end
        if (last_s) begin
          out_h_d = 10'd0;
          rd_h_d  = 10'd0;
          cnt_d   = 2'd0;
          buf0_d  = 8'd0;
          buf1_d  = 8'd0;
          gap_d   = '0;
          if (v_q < 9'(V_ACTIVE - 1)) begin
            state_d = S_LGAP;
            v_d     = v_q + 9'd1;
          end else begin
            state_d = S_TAIL;
          end
        end else begin
          state_d = S_LINE;
        end
      end
      S_TAIL: begin
        if (gap_q == GW'(LINE_GAP - 1)) begin
          gap_d = '0;
          v_d   = 9'd0;
          if (enable) begin
            state_d       = S_FGAP;
            frame_start_s = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      rd_h_q  <= 10'd0;
      out_h_q <= 10'd0;
      v_q     <= 9'd0;
      cnt_q   <= 2'd0;
      pend_q  <= 1'b0;
      buf0_q  <= 8'd0;
      buf1_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      rd_h_q  <= rd_h_d;
      out_h_q <= out_h_d;
      v_q     <= v_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

endmodule

// File: tb/tb_video_stream_source.sv
// Directed bench for video_stream_source: per-cycle vector table for the first line, then
// frame-level sequences for stall, enable drop, mid-line reset and (optionally) the test pattern.
module tb_video_stream_source;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int LG = 3;
  localparam int FG = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        main_sel;
  logic        mem_rd_en;
  logic [19:0] mem_rd_addr;
  logic [7:0]  mem_rd_data = 8'd0;
  logic        fv, lv, dv;
  logic        ready = 1'b1;
  logic [7:0]  dout;
  logic [19:0] addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef TEST_PATTERN_EN
  assign main_sel = 1'b0;
`else
  assign main_sel = 1'b1;  // must be ignored in the default build
`endif

  video_stream_source #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_GAP(LG), .FRAME_GAP(FG)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pattern_sel(main_sel),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .video_frame_valid(fv), .video_line_valid(lv), .video_data_valid(dv),
    .video_data_ready(ready), .video_data_out(dout), .video_address(addr)
  );

  typedef struct packed {
    logic        en;
    logic        rdy;
    logic        fv;
    logic        lv;
    logic        dv;
    logic        re;
    logic [7:0]  dout;
    logic [19:0] addr;
  } vec_t;

  vec_t tbl [0:18];

  logic [19:0] qa[$];
  logic [7:0]  qd[$];
  int rd_n = 0, acc_n = 0;
  int bad_occ = 0, bad_dv = 0, bad_rd = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-buffer model (data = low address byte) and transfer/occupancy monitor.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem_rd_addr[7:0];
    if (reset) begin
      if (dv && ready) begin
        qa.push_back(addr);
        qd.push_back(dout);
      end
      if (!lv) begin
        rd_n  = 0;
        acc_n = 0;
      end else begin
        rd_n  = rd_n + int'(mem_rd_en);
        acc_n = acc_n + int'(dv && ready);
      end
      if (rd_n - acc_n > 2) bad_occ++;
      if (dv && !lv) bad_dv++;
      if (mem_rd_en && !lv) bad_rd++;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, " frame_valid"}, fv, 0);
    check({tag, " line_valid"}, lv, 0);
    check({tag, " data_valid"}, dv, 0);
    check({tag, " mem_rd_en"}, mem_rd_en, 0);
    check({tag, " data_out"}, dout, 0);
    check({tag, " address"}, addr, 0);
  endtask

  task automatic check_frame(input string tag);
    logic [19:0] ea;
    int n;
    n = qa.size();
    check({tag, " pixel count"}, n, V * H);
    for (int i = 0; i < n && i < V * H; i++) begin
      ea = {9'(i / H), 1'b0, 10'(i % H)};
      check({tag, " address"}, qa[i], ea);
      check({tag, " data"}, qd[i], 8'(i % H));
    end
    qa.delete();
    qd.delete();
  endtask

  task automatic wait_frame_end(input string tag);
    bit seen, prev_lv, ok;
    int k;
    seen = fv; prev_lv = lv; ok = 1'b0; k = -1;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (prev_lv && !lv) k = 0;
      else if (k >= 0) k++;
      prev_lv = lv;
      if (seen && !fv) begin
        ok = 1'b1;
        break;
      end
      if (fv) seen = 1'b1;
    end
    check({tag, " frame end seen"}, ok, 1);
    check({tag, " line fall to frame fall"}, k, LG);
  endtask

  task automatic wait_for(input logic [19:0] a, input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk); #1;
      if (dv && addr == a) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, " pixel reached"}, ok, 1);
  endtask

`ifdef TEST_PATTERN_EN
  logic        p_en = 1'b0, p_sel = 1'b1, p_ready = 1'b1;
  logic [7:0]  p_rd_data = 8'h55;
  logic        p_rd_en, p_fv, p_lv, p_dv;
  logic [19:0] p_rd_addr, p_addr;
  logic [7:0]  p_dout, p_a = 8'd0, p_b = 8'd0;
  bit          p_a_seen = 1'b0, p_b_seen = 1'b0, p_rd_seen = 1'b0;

  video_stream_source #(.H_ACTIVE(64), .V_ACTIVE(32), .LINE_GAP(LG), .FRAME_GAP(FG)) u_pat (
    .clk(clk), .reset(reset), .enable(p_en), .pattern_sel(p_sel),
    .mem_rd_en(p_rd_en), .mem_rd_addr(p_rd_addr), .mem_rd_data(p_rd_data),
    .video_frame_valid(p_fv), .video_line_valid(p_lv), .video_data_valid(p_dv),
    .video_data_ready(p_ready), .video_data_out(p_dout), .video_address(p_addr)
  );

  // Captures the two probe pixels of the pattern instance.
  always @(posedge clk) begin
    if (reset && p_en) begin
      if (p_rd_en) p_rd_seen <= 1'b1;
      if (p_dv && p_addr == 20'd32) begin
        p_a <= p_dout;
        p_a_seen <= 1'b1;
      end
      if (p_dv && p_addr == {9'd16, 1'b0, 10'd32}) begin
        p_b <= p_dout;
        p_b_seen <= 1'b1;
      end
    end
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, rd_seen, fv_seen, lv_seen;

    for (int i = 0; i <= 4; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 20'd0};
    for (int i = 5; i <= 7; i++) tbl[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 20'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 20'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 20'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0, 20'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 20'd1};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd2, 20'd2};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd3, 20'd3};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 20'd4};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd5, 20'd5};
    tbl[16] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd6, 20'd6};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd7, 20'd7};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 20'h00800};

    // Reset held for 5 clocks with enable high.
    repeat (5) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    reset = 1'b1;

    // First frame, first line: cycle-accurate vectors from reset release.
    for (int i = 0; i <= 18; i++) begin
      if (i > 0) @(negedge clk);
      enable = tbl[i].en;
      ready  = tbl[i].rdy;
      #1;
      check($sformatf("vec%0d frame_valid", i), fv, tbl[i].fv);
      check($sformatf("vec%0d line_valid", i), lv, tbl[i].lv);
      check($sformatf("vec%0d data_valid", i), dv, tbl[i].dv);
      check($sformatf("vec%0d mem_rd_en", i), mem_rd_en, tbl[i].re);
      if (tbl[i].dv || !tbl[i].lv) begin
        check($sformatf("vec%0d data_out", i), dout, tbl[i].dout);
        check($sformatf("vec%0d address", i), addr, tbl[i].addr);
      end
    end
    wait_frame_end("frame1");
    check_frame("frame1");

    // Frame 2: stall 4 cycles on pixel h=3 of line 0.
    wait_for(20'd3, "stall");
    ready = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      check("stall data_valid", dv, 1);
      check("stall data_out", dout, 8'd3);
      check("stall address", addr, 20'd3);
    end
    ready = 1'b1;
    wait_frame_end("frame2");
    check_frame("frame2");

    // Frame 3: enable dropped during line 1.
    wait_for({9'd1, 1'b0, 10'd0}, "enable drop");
    enable = 1'b0;
    wait_frame_end("frame3");
    check_frame("frame3");
    rd_seen = 0; fv_seen = 0; lv_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      rd_seen += int'(mem_rd_en);
      fv_seen += int'(fv);
      lv_seen += int'(lv);
    end
    check("idle mem_rd_en cycles", rd_seen, 0);
    check("idle frame_valid cycles", fv_seen, 0);
    check("idle line_valid cycles", lv_seen, 0);
    check("idle data_out", dout, 0);
    check("idle address", addr, 0);

    // Frame 4: reset at pixel h=5 of line 2.
    enable = 1'b1;
    wait_for({9'd2, 1'b0, 10'd5}, "mid reset");
    reset = 1'b0;
    #1;
    check_outputs_zero("mid reset");
    repeat (3) @(negedge clk);
    qa.delete();
    qd.delete();
    reset = 1'b1;
    rise = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk); #1;
      if (fv) begin
        rise = c;
        break;
      end
    end
    check("frame_valid rise after reset", rise, FG);
    wait_frame_end("after reset");
    check_frame("after reset");
    enable = 1'b0;

    check("occupancy above 2", bad_occ, 0);
    check("data_valid outside line", bad_dv, 0);
    check("read outside line", bad_rd, 0);

`ifdef TEST_PATTERN_EN
    p_en = 1'b1;
    for (int c = 0; c < 6000 && !p_b_seen; c++) @(negedge clk);
    check("pattern pixel h32 v0 seen", p_a_seen, 1);
    check("pattern pixel h32 v16 seen", p_b_seen, 1);
    check("pattern pixel h32 v0", p_a, 8'd200);
    check("pattern pixel h32 v16", p_b, 8'd20);
    check("pattern mem_rd_en", p_rd_seen, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_stream_source.md
Name: video_stream_source

Overview:
- Generates the pixel stream consumed by the maze-processing blocks: video_frame_valid, video_line_valid, video_data_valid, video_data_out, video_address.
- Pixels are read from an external frame-buffer read port with 1-cycle read latency.
- A 2-entry prefetch buffer supports sink back-pressure.
- It is the transmitting end of the video stream interface used by the processing blocks; it is used as the on-chip source and as the bench driver.

Parameters:
- H_ACTIVE, 702, pixels per line (h = 0..H_ACTIVE-1).
- V_ACTIVE, 288, lines per frame (v = 0..V_ACTIVE-1).
- LINE_GAP, 16, clocks with video_line_valid low before each line, and after the last line before the frame drops.
- FRAME_GAP, 64, clocks with video_frame_valid low between frames.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled only in IDLE and at frame end.
- pattern_sel  in  1  selects the internal test pattern (used only when TEST_PATTERN_EN is defined).
- mem_rd_en  out  1  frame-buffer read strobe.
- mem_rd_addr  out  20  read address, same packing as video_address.
- mem_rd_data  in  8  read data; valid the cycle after mem_rd_en.
- video_frame_valid  out  1  high for the whole frame, including line gaps.
- video_line_valid  out  1  high from the start of a line until its last pixel is accepted.
- video_data_valid  out  1  pixel present on video_data_out.
- video_data_ready  in  1  sink accepts the pixel.
- video_data_out  out  8  pixel value.
- video_address  out  20  pixel address: {v[8:0], 1'b0, h[9:0]}.

Behaviour:
- Reset (reset = 0, asynchronous):
  - all outputs 0, state IDLE.
  - h/v counters and prefetch buffer cleared.
  - outstanding read discarded.
  - Applies equally mid-frame; no partial line is resumed.
- States: IDLE -> FGAP -> LGAP -> LINE -> (LGAP | TAIL) -> FGAP/IDLE.
  - IDLE: all outputs 0. Go to FGAP when enable = 1.
  - FGAP: frame_valid = 0 for FRAME_GAP clocks, then frame_valid = 1, v = 0, go to LGAP.
  - LGAP: frame_valid = 1, line_valid = 0 for LINE_GAP clocks, then go to LINE with h = 0.
  - LINE: line_valid = 1.
    - After the last pixel (h = H_ACTIVE-1) is accepted, line_valid drops on the next cycle.
    - Then go to LGAP if v < V_ACTIVE-1 (v increments); otherwise go to TAIL.
  - TAIL: LINE_GAP clocks with frame_valid = 1, then frame_valid = 0.
    - Go to FGAP if enable = 1, else go to IDLE.
- Handshake:
  - A pixel transfers on a cycle where video_data_valid & video_data_ready are both 1.
  - While valid = 1 and ready = 0, data_out and address are held stable and valid stays 1.
  - video_data_valid is never asserted outside LINE.
- Prefetch:
  - A read is issued when (buffer count + outstanding reads) < 2 and reads remain in the line.
  - Read addresses run h = 0..H_ACTIVE-1 for the current v.
  - Data is written into the buffer in the cycle after mem_rd_en.
  - data_valid = buffer non-empty.
  - Buffer never overflows; no reads are issued past the end of the line.
- Latency and rate:
  - If line_valid rises at cycle L, the first read is issued at L and video_data_valid first goes high at L+2.
  - With ready held at 1, one pixel is transferred per clock after that.
- Addressing: video_address is the address of the pixel presented, not of the read in flight.
- Enable:
  - Deasserting enable mid-frame completes the current frame normally, then goes to IDLE.
  - Asserting enable during TAIL continues directly to FGAP.
- Counter widths: h is 10 bits and v is 9 bits. No wrap occurs within legal parameter values (H_ACTIVE ≤ 1023, V_ACTIVE ≤ 511).

Optional Feature:
- Macro: TEST_PATTERN_EN.
- Defined, with pattern_sel = 1 (latched at frame start):
  - The memory port is idle (mem_rd_en = 0).
  - Pixels come from an internal generator: value = 8'd200 if (h[5] ^ v[4]) else 8'd20, with the same timing and latency (first valid at L+2).
- Not defined: pattern_sel is ignored and all pixels come from the memory port.

Test Plan:
- Reset: hold reset = 0 for 5 clocks with enable = 1 -> all outputs 0. Release -> frame_valid rises exactly FRAME_GAP clocks later.
- Full frame, no stall: H_ACTIVE = 8, V_ACTIVE = 4, LINE_GAP = 3, FRAME_GAP = 5, ready = 1, mem_rd_data = low byte of the address.
  - 4 lines of 8 pixels each.
  - Addresses {v, 0, h} in order.
  - data_valid first high at L+2.
  - Frame drops 3 clocks after the last line_valid fall.
- Back-pressure: ready = 0 for 4 cycles on pixel h = 3 -> data_out and address held, no pixel lost or duplicated, mem_rd_en never causes more than 2 buffered plus outstanding reads.
- Enable drop: enable = 0 during line v = 1 -> frame completes all 4 lines, then IDLE with frame_valid = 0 and no further mem_rd_en.
- Reset mid-line: assert reset at h = 5 of v = 2 -> outputs 0 immediately. After release, the next frame starts at v = 0, h = 0.
- TEST_PATTERN_EN defined, pattern_sel = 1: with H_ACTIVE = 64, V_ACTIVE = 32, pixel (h = 32, v = 0) = 200 and (h = 32, v = 16) = 20; mem_rd_en stays 0.
